// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer and its arithmetic core.
package mdu_sequencer_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    // Counter width for the default latencies; the divide latency is the longer one.
    localparam int CNT_W = $clog2(DIV_LAT_DEF + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    // Codes other than div/divu fall back to mult.
    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_sequencer_arith.sv
// Combinational multiply/divide datapath working on the latched operands.
module mdu_arith
    import mdu_sequencer_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    // Signed divide is done on magnitudes; 0x80000000 / -1 then wraps back to 0x80000000 on its own.
    always_comb begin
        a_neg    = (op == MDU_DIV) & a[31];
        b_neg    = (op == MDU_DIV) & b[31];
        a_mag    = a_neg ? (32'd0 - a) : a;
        b_mag    = b_neg ? (32'd0 - b) : b;
        div_zero = op_is_div(op) & (b == 32'd0);
        b_safe   = (b == 32'd0) ? 32'd1 : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem      = a_neg ? (32'd0 - r_mag) : r_mag;
        prod_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u   = {32'd0, a} * {32'd0, b};
    end

    // Select the {HI, LO} pair for the operation.
    always_comb begin
        result = prod_s;
        case (op)
            MDU_MULTU:         result = prod_u;
            MDU_DIV, MDU_DIVU: result = {rem, quot};
            default:           result = prod_s;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide sequencer: latency counter, HI/LO ownership, D-stage stall.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | counter 0; accepts start, mthi, mtlo
//   ST_RUN  | counter counting down; commit to HI/LO when it leaves 1
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic        hi_we_i,
    input  logic        lo_we_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        flush_i,
    input  logic        is_mdft_d_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    mdu_state_t  state;
    mdu_state_t  state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic        load;
    logic        commit;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] result;
    logic        div_zero;
    logic        hi_wr;
    logic        lo_wr;

    mdu_arith u_arith (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .result   (result),
        .div_zero (div_zero)
    );

    // State and latency counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: load the counter on an accepted start, commit when it reaches terminal count.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load     = 1'b0;
        commit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    state_nx = ST_RUN;
                    load     = 1'b1;
                    cnt_nx   = op_is_div(op_i) ? CW'(DIV_LAT) : CW'(MULT_LAT);
                end
            end
            ST_RUN: begin
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx = ST_IDLE;
                    commit   = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Operand latch; later E-stage values must not disturb an operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= MDU_MULT;
            a_q  <= '0;
            b_q  <= '0;
        end else if (load) begin
            op_q <= op_i;
            a_q  <= rs_i;
            b_q  <= rt_i;
        end
    end

    // mthi/mtlo only land while idle; a flushed E-stage write is dropped.
    always_comb begin
        hi_wr = hi_we_i & ~flush_i & (state == ST_IDLE);
        lo_wr = lo_we_i & ~flush_i & (state == ST_IDLE);
    end

    // HI/LO: result commit (skipped on divide by zero) or direct moves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (commit) begin
            if (!div_zero) begin
                hi_o <= result[63:32];
                lo_o <= result[31:0];
            end
        end else begin
            if (hi_wr) hi_o <= rs_i;
            if (lo_wr) lo_o <= rs_i;
        end
    end

    // Busy comes straight from the state register; stall also covers the start cycle itself.
    always_comb begin
        busy_o  = (state == ST_RUN);
        stall_o = is_mdft_d_i & (start_i | busy_o);
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer against a plain-arithmetic HI/LO model.
module tb_mdu_sequencer;

    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic        hi_we_i = 1'b0;
    logic        lo_we_i = 1'b0;
    logic [31:0] rs_i = 32'd0;
    logic [31:0] rt_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        is_mdft_d_i = 1'b0;
    logic        busy_o;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .op_i        (op_i),
        .hi_we_i     (hi_we_i),
        .lo_we_i     (lo_we_i),
        .rs_i        (rs_i),
        .rt_i        (rt_i),
        .flush_i     (flush_i),
        .is_mdft_d_i (is_mdft_d_i),
        .busy_o      (busy_o),
        .stall_o     (stall_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    always #5 clk = ~clk;

    // The stimulus must never present the combinations the decode logic forbids.
    always @(posedge clk) begin
        if (reset && ((busy_o && (start_i || hi_we_i || lo_we_i)) || (start_i && (hi_we_i || lo_we_i)))) begin
            mismatched++;
            $error("FAIL illegal_combo: busy %0b start %0b hi_we %0b lo_we %0b", busy_o, start_i, hi_we_i, lo_we_i);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result from the architectural rules, using 64-bit integer arithmetic.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd2: begin
                if (b != 32'd0) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            3'd3: begin
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: begin
                q = sa * sb;
                m_hi = q[63:32];
                m_lo = q[31:0];
            end
        endcase
    endtask

    // Issue one start in the current (idle) cycle and follow it to completion.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic mdft, input logic flush);
        int lat;
        start_i     = 1'b1;
        op_i        = op;
        rs_i        = a;
        rt_i        = b;
        flush_i     = flush;
        is_mdft_d_i = mdft;
        #1;
        check({tag, "/stall_issue"}, 64'(stall_o), 64'(mdft));
        tick();
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = 3'($urandom_range(0, 7));
        rs_i    = $urandom;
        rt_i    = $urandom;
        #1;
        if (flush) begin
            check({tag, "/busy_flushed"}, 64'(busy_o), 64'd0);
            check({tag, "/hi_flushed"}, 64'(hi_o), 64'(m_hi));
            check({tag, "/lo_flushed"}, 64'(lo_o), 64'(m_lo));
        end else begin
            lat = (op == 3'd2 || op == 3'd3) ? DL : ML;
            for (int i = 0; i < lat; i++) begin
                check({tag, "/busy_run"}, 64'(busy_o), 64'd1);
                check({tag, "/stall_run"}, 64'(stall_o), 64'(mdft));
                check({tag, "/hi_hold"}, 64'(hi_o), 64'(m_hi));
                tick();
            end
            model_op(op, a, b);
            check({tag, "/busy_done"}, 64'(busy_o), 64'd0);
            check({tag, "/stall_done"}, 64'(stall_o), 64'd0);
            check({tag, "/hi"}, 64'(hi_o), 64'(m_hi));
            check({tag, "/lo"}, 64'(lo_o), 64'(m_lo));
        end
        is_mdft_d_i = 1'b0;
    endtask

    // mthi/mtlo in the current cycle; result is visible one cycle later.
    task automatic run_mt(input string tag, input logic hw, input logic lw,
                          input logic [31:0] val, input logic flush);
        hi_we_i = hw;
        lo_we_i = lw;
        rs_i    = val;
        flush_i = flush;
        tick();
        hi_we_i = 1'b0;
        lo_we_i = 1'b0;
        flush_i = 1'b0;
        rs_i    = $urandom;
        if (!flush) begin
            if (hw) m_hi = val;
            if (lw) m_lo = val;
        end
        check({tag, "/hi"}, 64'(hi_o), 64'(m_hi));
        check({tag, "/lo"}, 64'(lo_o), 64'(m_lo));
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          kind;

        // Reset state.
        is_mdft_d_i = 1'b1;
        tick();
        tick();
        check("reset/busy", 64'(busy_o), 64'd0);
        check("reset/stall", 64'(stall_o), 64'd0);
        check("reset/hi", 64'(hi_o), 64'd0);
        check("reset/lo", 64'(lo_o), 64'd0);
        is_mdft_d_i = 1'b0;
        reset = 1'b1;
        tick();

        // Directed cases.
        run_op("mult_neg1x2", 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check("mult_neg1x2/hi_const", 64'(hi_o), 64'h0000_0000_FFFF_FFFF);
        check("mult_neg1x2/lo_const", 64'(lo_o), 64'h0000_0000_FFFF_FFFE);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 1'b1, 1'b0);
        check("divu_100_7/hi_const", 64'(hi_o), 64'd2);
        check("divu_100_7/lo_const", 64'(lo_o), 64'd14);
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div_m7_2/lo_const", 64'(lo_o), 64'h0000_0000_FFFF_FFFD);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("div_ovf/lo_const", 64'(lo_o), 64'h0000_0000_8000_0000);
        check("div_ovf/hi_const", 64'(hi_o), 64'd0);
        run_mt("mt_seed", 1'b1, 1'b1, 32'h5555_AAAA, 1'b0);
        run_op("div_zero", 3'd2, 32'd1234, 32'd0, 1'b1, 1'b0);
        run_op("divu_zero", 3'd3, 32'd99, 32'd0, 1'b0, 1'b0);
        run_mt("mthi_flush", 1'b1, 1'b0, 32'h0000_1234, 1'b1);
        run_mt("mthi", 1'b1, 1'b0, 32'h0000_1234, 1'b0);
        run_mt("mtlo", 1'b0, 1'b1, 32'h0000_CAFE, 1'b0);
        run_op("start_flush", 3'd0, 32'd5, 32'd6, 1'b1, 1'b1);
        run_op("multu_a", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("multu_b2b", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
        run_op("other_op", 3'd6, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);

        // Randomized mix of operations and moves.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 5);
            ra   = $urandom;
            rb   = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
            if (kind < 4) begin
                rop = 3'($urandom_range(0, 7));
                run_op("rand_op", rop, ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
            end else begin
                run_mt("rand_mt", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                       ($urandom_range(0, 4) == 0));
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end

        // Asynchronous reset in the third busy cycle of a divide.
        run_mt("pre_reset", 1'b1, 1'b1, 32'hA5A5_5A5A, 1'b0);
        start_i     = 1'b1;
        op_i        = 3'd2;
        rs_i        = 32'd1000;
        rt_i        = 32'd3;
        is_mdft_d_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("midreset/busy", 64'(busy_o), 64'd0);
        check("midreset/stall", 64'(stall_o), 64'd0);
        check("midreset/hi", 64'(hi_o), 64'd0);
        check("midreset/lo", 64'(lo_o), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("post_reset/busy", 64'(busy_o), 64'd0);
        check("post_reset/hi", 64'(hi_o), 64'd0);
        check("post_reset/lo", 64'(lo_o), 64'd0);
        is_mdft_d_i = 1'b0;
        run_op("post_reset_mult", 3'd0, 32'd123456, 32'hFFFF_FF00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
